// File: rtl/pipe_inv_if.sv
// pipe_inv_if: handshake bundle for pipe_inv.
//   f, b, c, d  - forward result and the operands used to form it
//   in_valid    - f/b/c/d valid this cycle
//   in_ready    - block accepts input this cycle
//   a           - recovered operand
//   out_valid   - a valid
//   out_ready   - downstream accepts a this cycle
//   count       - transactions in flight, 0..3
// slave is the block's view, master is the driver/consumer view.
interface pipe_inv_if #(
    parameter int unsigned N = 10
);
    logic [N-1:0] f;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   count;

    modport slave (
        input  f, b, c, d, in_valid, out_ready,
        output in_ready, a, out_valid, count
    );

    modport master (
        output f, b, c, d, in_valid, out_ready,
        input  in_ready, a, out_valid, count
    );
endinterface

// File: rtl/pipe_inv.sv
// pipe_inv: three-stage pipelined inverse of the forward adder pipeline.
// Recovers A = F - B - C (mod 2^N) through stages mirroring the forward block:
//   stage 1: x1 = F - B, x2 = C - D, d1 = D
//   stage 2: x3 = x1 - x2, d2 = d1
//   stage 3: a  = x3 - d2
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus_io - pipe_inv_if slave modport (input F/B/C/D handshake, output A
//            handshake, in-flight count)
module pipe_inv #(
    parameter int unsigned N = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_inv_if.slave  bus_io
);

    logic         v1_q, v1_d;
    logic         v2_q, v2_d;
    logic         v3_q, v3_d;
    logic [N-1:0] x1_q, x1_d;
    logic [N-1:0] x2_q, x2_d;
    logic [N-1:0] d1_q, d1_d;
    logic [N-1:0] x3_q, x3_d;
    logic [N-1:0] d2_q, d2_d;
    logic [N-1:0] a_q,  a_d;
    logic [1:0]   count_q, count_d;

    logic adv1, adv2, adv3;
    logic in_xfer, out_xfer;

    always_comb begin
        // Ready ripples back combinationally so a bubble anywhere lets the
        // stages behind it advance even while stage 3 is stalled.
        adv3 = !v3_q || bus_io.out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;

        in_xfer  = bus_io.in_valid && adv1;
        out_xfer = v3_q && bus_io.out_ready;

        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        d1_d    = d1_q;
        x3_d    = x3_q;
        d2_d    = d2_q;
        a_d     = a_q;
        count_d = count_q;

        // Data loads unconditionally on advance; it is only meaningful when
        // the accompanying valid bit is set.
        if (adv1) begin
            v1_d = bus_io.in_valid;
            x1_d = bus_io.f - bus_io.b;
            x2_d = bus_io.c - bus_io.d;
            d1_d = bus_io.d;
        end

        if (adv2) begin
            v2_d = v1_q;
            x3_d = x1_q - x2_q;
            d2_d = d1_q;
        end

        if (adv3) begin
            v3_d = v2_q;
            a_d  = x3_q - d2_q;
        end

        if (in_xfer && !out_xfer) begin
            count_d = count_q + 2'd1;
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            d1_q    <= '0;
            x3_q    <= '0;
            d2_q    <= '0;
            a_q     <= '0;
            count_q <= 2'd0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            d1_q    <= d1_d;
            x3_q    <= x3_d;
            d2_q    <= d2_d;
            a_q     <= a_d;
            count_q <= count_d;
        end
    end

    assign bus_io.in_ready  = adv1;
    assign bus_io.a         = a_q;
    assign bus_io.out_valid = v3_q;
    assign bus_io.count     = count_q;

endmodule

// File: tb/tb_pipe_inv.sv
// tb_pipe_inv: randomized scoreboard bench for pipe_inv.
// The driver pushes the operand A that produced each accepted F; the monitor
// pops on every output transfer and also tracks occupancy as
// accepted-minus-delivered.
module tb_pipe_inv;

    localparam int unsigned N = 10;

    typedef struct {
        logic [N-1:0] a;
        int           acc_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_inv_if #(.N(N)) bus ();

    pipe_inv #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   occ = 0;
    logic strict_lat = 1'b0;
    int   stall_pct = 0;
    logic force_lo = 1'b0;
    logic prev_hold = 1'b0;
    logic [N-1:0] prev_a = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input int req);
        n_vec++;
        if (act !== 32'(req)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            // The coming edge resets the pipe, so in-flight work is discarded.
            sb.delete();
            occ = 0;
            prev_hold = 1'b0;
        end else begin
            check("count", {30'd0, bus.count}, occ);
            check("in_ready", {31'd0, bus.in_ready},
                  (occ == 3 && !bus.out_ready) ? 0 : 1);
            if (prev_hold) begin
                check("hold_valid", {31'd0, bus.out_valid}, 1);
                check("hold_a", {22'd0, bus.a}, int'(prev_a));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_output: got a=%0d, expected no output", bus.a);
                end else begin
                    e = sb.pop_front();
                    check("a", {22'd0, bus.a}, int'(e.a));
                    if (strict_lat) check("latency", 32'(cyc + 1 - e.acc_edge), 3);
                end
            end
            occ = occ + ((bus.in_valid && bus.in_ready) ? 1 : 0)
                      - ((bus.out_valid && bus.out_ready) ? 1 : 0);
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_a = bus.a;
        end
    end

    task automatic drive_cycle(input logic v, input logic [N-1:0] f, input logic [N-1:0] b,
                               input logic [N-1:0] c, input logic [N-1:0] d,
                               input logic [N-1:0] ea, output logic acc);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.f = f;
        bus.b = b;
        bus.c = c;
        bus.d = d;
        bus.out_ready = force_lo ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
        #3;
        acc = v && bus.in_ready;
        if (acc) sb.push_back('{a: ea, acc_edge: cyc + 1});
    endtask

    task automatic send(input logic [N-1:0] f, input logic [N-1:0] b, input logic [N-1:0] c,
                        input logic [N-1:0] d, input logic [N-1:0] ea);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) drive_cycle(1'b1, f, b, c, d, ea, acc);
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: input not accepted within 200 cycles");
        end
    endtask

    task automatic rand_vec(output logic [N-1:0] f, output logic [N-1:0] b,
                            output logic [N-1:0] c, output logic [N-1:0] d,
                            output logic [N-1:0] a);
        a = N'($urandom);
        b = N'($urandom);
        c = N'($urandom);
        d = N'($urandom);
        f = a + b + c;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 200 && (sb.size() != 0 || occ != 0); i++)
            drive_cycle(1'b0, '0, '0, '0, '0, '0, acc);
        check("drain_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        logic [N-1:0] f, b, c, d, a;
        logic acc;
        int accepted;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.f = '0;
        bus.b = '0;
        bus.c = '0;
        bus.d = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_a", {22'd0, bus.a}, 0);
        check("rst_count", {30'd0, bus.count}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);

        // Basic recovery and wrap-around, stall-free so latency is exact.
        strict_lat = 1'b1;
        stall_pct = 0;
        send(10'd32, 10'd7, 10'd20, 10'd3, 10'd5);
        drain();
        send(10'd0, 10'd1, 10'd0, 10'd0, 10'd1023);
        send(10'd5, 10'd1023, 10'd1023, 10'd512, 10'd7);
        drain();

        // Back-to-back streaming.
        for (int i = 0; i < 20; i++) begin
            rand_vec(f, b, c, d, a);
            drive_cycle(1'b1, f, b, c, d, a, acc);
            check("stream_in_ready", {31'd0, acc}, 1);
        end
        drain();
        strict_lat = 1'b0;

        // Backpressure: stall the output for 5 cycles while offering input.
        force_lo = 1'b1;
        rand_vec(f, b, c, d, a);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, f, b, c, d, a, acc);
            if (acc) rand_vec(f, b, c, d, a);
        end
        check("full_count", {30'd0, bus.count}, 3);
        check("full_in_ready", {31'd0, bus.in_ready}, 0);
        force_lo = 1'b0;
        drain();

        // Random valid/ready.
        stall_pct = 50;
        accepted = 0;
        for (int i = 0; i < 5000 && accepted < 500; i++) begin
            rand_vec(f, b, c, d, a);
            drive_cycle(1'($urandom_range(0, 1)), f, b, c, d, a, acc);
            if (acc) accepted++;
        end
        check("random_accepted", 32'(accepted), 500);
        stall_pct = 0;
        drain();

        // Reset with two transactions in flight.
        force_lo = 1'b1;
        rand_vec(f, b, c, d, a);
        send(f, b, c, d, a);
        rand_vec(f, b, c, d, a);
        send(f, b, c, d, a);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        check("pre_reset_count", {30'd0, bus.count}, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        force_lo = 1'b0;
        check("post_rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("post_rst_a", {22'd0, bus.a}, 0);
        check("post_rst_count", {30'd0, bus.count}, 0);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 1);
        strict_lat = 1'b1;
        rand_vec(f, b, c, d, a);
        send(f, b, c, d, a);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
